// File: rtl/pipelined_muldiv_alu_pkg.sv
// Shared opcode constants, FSM encoding and iterative-engine op kinds for pipelined_muldiv_alu.
// ALU_DIV_EN (when defined) makes DIV/REM real operations instead of undefined opcodes.
package pipelined_muldiv_alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_CEQ = 4'd2;
  localparam logic [3:0] ALU_CLT = 4'd3;
  localparam logic [3:0] ALU_CLE = 4'd4;
  localparam logic [3:0] ALU_AND = 4'd5;
  localparam logic [3:0] ALU_ORR = 4'd6;
  localparam logic [3:0] ALU_XOR = 4'd7;
  localparam logic [3:0] ALU_SHL = 4'd8;
  localparam logic [3:0] ALU_SHR = 4'd9;
  localparam logic [3:0] ALU_SRA = 4'd10;
  localparam logic [3:0] ALU_MUL = 4'd11;
  localparam logic [3:0] ALU_DIV = 4'd12;
  localparam logic [3:0] ALU_REM = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  typedef enum logic [1:0] {
    ENG_MUL = 2'd0,
    ENG_DIV = 2'd1,
    ENG_REM = 2'd2
  } eng_op_t;

  function automatic logic is_iterative(input logic [3:0] op);
`ifdef ALU_DIV_EN
    return (op == ALU_MUL) || (op == ALU_DIV) || (op == ALU_REM);
`else
    return (op == ALU_MUL);
`endif
  endfunction

endpackage

// File: rtl/pipelined_muldiv_alu_engine.sv
// Iterative MUL (shift-add) and, with ALU_DIV_EN, restoring DIV/REM: one bit per cycle.
// start loads operands; done pulses in the cycle of the final iteration with result valid.
module alu_iterative_engine
  import pipelined_muldiv_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  eng_op_t          op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic             busy_reg;
  logic [CNT_W-1:0] count_reg;
  eng_op_t          op_reg;
  // acc: product / partial remainder; a: multiplicand / divisor; b: multiplier / dividend-quotient
  logic [WIDTH-1:0] acc_reg, a_reg, b_reg;
  logic [WIDTH-1:0] acc_next, a_next, b_next;

`ifdef ALU_DIV_EN
  logic [WIDTH:0]   rem_shift;
  logic             take;
`endif

  always_comb begin
    acc_next = b_reg[0] ? (acc_reg + a_reg) : acc_reg;
    a_next   = a_reg << 1;
    b_next   = b_reg >> 1;
`ifdef ALU_DIV_EN
    rem_shift = {acc_reg, b_reg[WIDTH-1]};
    // A zero divisor always "fits", giving all-ones quotient and remainder = dividend.
    take      = (rem_shift >= {1'b0, a_reg});
    if (op_reg != ENG_MUL) begin
      a_next   = a_reg;
      b_next   = {b_reg[WIDTH-2:0], take};
      acc_next = take ? WIDTH'(rem_shift - {1'b0, a_reg}) : rem_shift[WIDTH-1:0];
    end
`endif
  end

  assign done   = busy_reg && (count_reg == CNT_W'(WIDTH - 1));
  assign result = (op_reg == ENG_DIV) ? b_next : acc_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg  <= 1'b0;
      count_reg <= '0;
      op_reg    <= ENG_MUL;
      acc_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
    end else if (start) begin
      busy_reg  <= 1'b1;
      count_reg <= '0;
      op_reg    <= op;
      acc_reg   <= '0;
      a_reg     <= (op == ENG_MUL) ? x : y;
      b_reg     <= (op == ENG_MUL) ? y : x;
    end else if (busy_reg) begin
      acc_reg   <= acc_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      count_reg <= count_reg + CNT_W'(1);
      if (done) busy_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/pipelined_muldiv_alu.sv
// Execute-stage ALU with valid/ready handshake: 1-cycle ops here, MUL/DIV/REM in the engine.
// Define ALU_DIV_EN to build DIV/REM; otherwise they report Illegal like undefined opcodes.
module pipelined_muldiv_alu
  import pipelined_muldiv_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op_code,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             illegal
);

  localparam int SHAMT_W = $clog2(WIDTH);

  alu_state_t         state_reg, state_next;
  logic               accept, start, eng_done;
  logic [WIDTH-1:0]   eng_result;
  eng_op_t            eng_op;
  logic [WIDTH-1:0]   quick_z;
  logic               quick_illegal;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   z_reg;
  logic               illegal_reg;

  always_comb begin
    quick_z       = '0;
    quick_illegal = 1'b0;
    shamt         = y[SHAMT_W-1:0];
    case (op_code)
      ALU_ADD: quick_z = x + y;
      ALU_SUB: quick_z = x - y;
      ALU_CEQ: quick_z = WIDTH'(x == y);
      ALU_CLT: quick_z = WIDTH'(x < y);
      ALU_CLE: quick_z = WIDTH'(x <= y);
      ALU_AND: quick_z = x & y;
      ALU_ORR: quick_z = x | y;
      ALU_XOR: quick_z = x ^ y;
      ALU_SHL: quick_z = x << shamt;
      ALU_SHR: quick_z = x >> shamt;
      ALU_SRA: quick_z = $unsigned($signed(x) >>> shamt);
      ALU_MUL: quick_z = '0;
`ifdef ALU_DIV_EN
      ALU_DIV, ALU_REM: quick_z = '0;
`endif
      default: quick_illegal = 1'b1;
    endcase
  end

  always_comb begin
    eng_op = ENG_MUL;
    if (op_code == ALU_DIV) eng_op = ENG_DIV;
    else if (op_code == ALU_REM) eng_op = ENG_REM;
  end

  // Handshake FSM: a result being consumed frees the slot for a new op in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = (state_reg == ST_IDLE) || ((state_reg == ST_DONE) && out_ready);
    accept     = in_valid && in_ready;
    start      = accept && is_iterative(op_code);
    case (state_reg)
      ST_IDLE: if (accept) state_next = start ? ST_BUSY : ST_DONE;
      ST_BUSY: if (eng_done) state_next = ST_DONE;
      ST_DONE: begin
        if (accept)         state_next = start ? ST_BUSY : ST_DONE;
        else if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_reg       <= '0;
      illegal_reg <= 1'b0;
    end else if (accept) begin
      z_reg       <= quick_z;
      illegal_reg <= quick_illegal;
    end else if (eng_done) begin
      z_reg       <= eng_result;
    end
  end

  alu_iterative_engine #(.WIDTH(WIDTH)) u_engine (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (eng_op),
    .x      (x),
    .y      (y),
    .done   (eng_done),
    .result (eng_result)
  );

  assign out_valid = (state_reg == ST_DONE);
  assign z         = z_reg;
  assign illegal   = illegal_reg;

endmodule

// File: tb/tb_pipelined_muldiv_alu.sv
// Bench for pipelined_muldiv_alu: transaction-level model with per-cycle checks plus literal vectors.
// Honours ALU_DIV_EN the same way as the design.
module tb_pipelined_muldiv_alu;
  import pipelined_muldiv_alu_pkg::*;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       op_code = 4'd0;
  logic [WIDTH-1:0] x = '0;
  logic [WIDTH-1:0] y = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] z;
  logic             illegal;

  int cmp_count = 0;
  int err_count = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] z;
    logic        ill;
    int          lat;
    int          t_in;
  } exp_t;

  exp_t q[$];
  logic mon_exp_valid, mon_exp_ready;

  pipelined_muldiv_alu #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_code   (op_code),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_count++;
    if (act !== exp) begin
      err_count++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // What the ALU must produce, straight from the operation definitions.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input int t);
    exp_t e;
    e.z = '0; e.ill = 1'b0; e.lat = 1; e.t_in = t;
    case (op)
      ALU_ADD: e.z = a + b;
      ALU_SUB: e.z = a - b;
      ALU_CEQ: e.z = (a == b) ? 32'd1 : 32'd0;
      ALU_CLT: e.z = (a < b) ? 32'd1 : 32'd0;
      ALU_CLE: e.z = (a <= b) ? 32'd1 : 32'd0;
      ALU_AND: e.z = a & b;
      ALU_ORR: e.z = a | b;
      ALU_XOR: e.z = a ^ b;
      ALU_SHL: e.z = a << (b % WIDTH);
      ALU_SHR: e.z = a >> (b % WIDTH);
      ALU_SRA: e.z = 32'($signed(a) >>> (b % WIDTH));
      ALU_MUL: begin e.z = 32'(64'(a) * 64'(b)); e.lat = WIDTH + 1; end
`ifdef ALU_DIV_EN
      ALU_DIV: begin e.z = (b == 0) ? 32'hFFFF_FFFF : a / b; e.lat = WIDTH + 1; end
      ALU_REM: begin e.z = (b == 0) ? a : a % b; e.lat = WIDTH + 1; end
`endif
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Compare process: outputs checked against the transaction queue every cycle.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_z", z, 32'd0);
      check("rst_illegal", {31'b0, illegal}, 32'd0);
    end else begin
      mon_exp_valid = (q.size() > 0) && ((cyc - q[0].t_in) >= q[0].lat);
      check("out_valid", {31'b0, out_valid}, {31'b0, mon_exp_valid});
      if (mon_exp_valid) begin
        check("z", z, q[0].z);
        check("illegal", {31'b0, illegal}, {31'b0, q[0].ill});
      end
      mon_exp_ready = (q.size() == 0) || (mon_exp_valid && out_ready);
      check("in_ready", {31'b0, in_ready}, {31'b0, mon_exp_ready});
      if (mon_exp_valid && out_ready) begin
        $display("result cycle=%0d z=%h illegal=%0d", cyc, z, illegal);
        void'(q.pop_front());
      end
      if (in_valid && in_ready) q.push_back(model(op_code, x, y, cyc));
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      output int t_acc);
    op_code = op; x = a; y = b; in_valid = 1'b1; t_acc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin t_acc = cyc; break; end
    end
    if (t_acc < 0) begin
      cmp_count++; err_count++;
      $display("FAIL send_timeout: in_ready stayed %0d want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; x = $urandom; y = $urandom; op_code = 4'hE;
  endtask

  task automatic wait_result(input string name, input logic [31:0] ez, input logic eill,
                             output int t_out);
    t_out = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin t_out = cyc; break; end
    end
    if (t_out < 0) begin
      cmp_count++; err_count++;
      $display("FAIL %s_timeout: out_valid %0d want 1", name, out_valid);
    end else begin
      check({name, "_z"}, z, ez);
      check({name, "_illegal"}, {31'b0, illegal}, {31'b0, eill});
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input string name, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] ez, input logic eill, input int elat);
    int t_acc, t_out;
    send(op, a, b, t_acc);
    wait_result(name, ez, eill, t_out);
    if (t_acc >= 0 && t_out >= 0) check({name, "_latency"}, t_out - t_acc, elat);
  endtask

  int t;

  initial begin
    #3 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("ready_after_reset", {31'b0, in_ready}, 32'd1);

    run("add_wrap",  ALU_ADD, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 1'b0, 1);
    run("sra",       ALU_SRA, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1);
    run("shr",       ALU_SHR, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b0, 1);
    run("sub_wrap",  ALU_SUB, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0, 1);
    run("ceq",       ALU_CEQ, 32'd7,         32'd7,         32'd1,         1'b0, 1);
    run("clt_false", ALU_CLT, 32'd5,         32'd3,         32'd0,         1'b0, 1);
    run("clt_uns",   ALU_CLT, 32'h8000_0000, 32'd1,         32'd0,         1'b0, 1);
    run("cle_eq",    ALU_CLE, 32'd3,         32'd3,         32'd1,         1'b0, 1);
    run("and",       ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1);
    run("orr",       ALU_ORR, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1);
    run("shl_31",    ALU_SHL, 32'd1,         32'd31,        32'h8000_0000, 1'b0, 1);
    run("shl_wrap",  ALU_SHL, 32'd1,         32'h0000_0020, 32'd1,         1'b0, 1);
    run("shr_31",    ALU_SHR, 32'hFFFF_FFFF, 32'd31,        32'd1,         1'b0, 1);
    run("mul",       ALU_MUL, 32'h0001_0003, 32'h0001_0002, 32'h0005_0006, 1'b0, 33);
    run("mul_max",   ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33);
`ifdef ALU_DIV_EN
    run("div",       ALU_DIV, 32'd100,       32'd7,         32'd14,        1'b0, 33);
    run("rem",       ALU_REM, 32'd100,       32'd7,         32'd2,         1'b0, 33);
    run("div_zero",  ALU_DIV, 32'd100,       32'd0,         32'hFFFF_FFFF, 1'b0, 33);
    run("rem_zero",  ALU_REM, 32'd9,         32'd0,         32'd9,         1'b0, 33);
    run("div_big",   ALU_DIV, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 1'b0, 33);
`else
    run("div_off",   ALU_DIV, 32'd100,       32'd7,         32'd0,         1'b1, 1);
    run("rem_off",   ALU_REM, 32'd100,       32'd7,         32'd0,         1'b1, 1);
`endif
    run("undef",     4'hF,    32'd1,         32'd2,         32'd0,         1'b1, 1);

    // Output stall, then result consumed and next op accepted in the same cycle.
    out_ready = 1'b0;
    send(ALU_CLT, 32'd3, 32'd5, t);
    repeat (5) begin
      @(negedge clk);
      check("stall_z", z, 32'd1);
      check("stall_valid", {31'b0, out_valid}, 32'd1);
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1; op_code = ALU_XOR; x = 32'h00FF_00FF; y = 32'h0F0F_0F0F; in_valid = 1'b1;
    @(negedge clk);
    check("same_cycle_in", {31'b0, in_ready}, 32'd1);
    check("same_cycle_out", {31'b0, out_valid}, 32'd1);
    check("same_cycle_z", z, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; x = $urandom; y = $urandom; op_code = 4'hE;
    @(negedge clk);
    check("xor_next_valid", {31'b0, out_valid}, 32'd1);
    check("xor_next_z", z, 32'h0FF0_0FF0);
    @(posedge clk); #1;

    // Back-to-back stream mixing 1-cycle and iterative ops (checked by the compare process).
    send(ALU_ADD, 32'd10, 32'd20, t);
    send(ALU_MUL, 32'd1234, 32'd5678, t);
    send(ALU_SUB, 32'd1, 32'd2, t);
    send(ALU_XOR, 32'hAAAA_5555, 32'hFFFF_0000, t);
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of a MUL: result must never appear.
    send(ALU_MUL, 32'd5, 32'd6, t);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_abort_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    run("after_rst", ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
